// File: rtl/cell_chain_sequencer_if.sv
// -----------------------------------------------------------------------------
// cell_chain_sequencer_if
// Bundles the request/result handshake and the shared cell-slot signals of the
// bit-serial cell chain sequencer.
//   start, a, b, k_init, z_init      : operation request (driver -> sequencer)
//   busy, done, res_x, res_y, res_z  : status and results (sequencer -> driver)
//   cell_sel, cell_x..cell_l         : cell slot inputs (sequencer -> cell)
//   cell_sx, cell_sy, cell_sk, cell_sz : cell slot outputs (cell -> sequencer)
// Modports: slave = sequencer side, master = driver/cell side.
// -----------------------------------------------------------------------------
interface cell_chain_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             k_init;
  logic             z_init;
  logic [1:0]       cell_sel;
  logic             cell_x;
  logic             cell_y;
  logic             cell_k;
  logic             cell_z;
  logic             cell_w;
  logic             cell_l;
  logic             cell_sx;
  logic             cell_sy;
  logic             cell_sk;
  logic             cell_sz;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_x;
  logic [WIDTH-1:0] res_y;
  logic             res_z;

  modport slave (
    input  start, a, b, k_init, z_init,
    input  cell_sx, cell_sy, cell_sk, cell_sz,
    output cell_sel, cell_x, cell_y, cell_k, cell_z, cell_w, cell_l,
    output busy, done, res_x, res_y, res_z
  );

  modport master (
    output start, a, b, k_init, z_init,
    output cell_sx, cell_sy, cell_sk, cell_sz,
    input  cell_sel, cell_x, cell_y, cell_k, cell_z, cell_w, cell_l,
    input  busy, done, res_x, res_y, res_z
  );
endinterface

// File: rtl/cell_chain_sequencer.sv
// -----------------------------------------------------------------------------
// cell_chain_sequencer
// Time-multiplexes one iterative-array cell slot over a WIDTH-bit operand pair,
// LSB first: one initial cell (CI), WIDTH-2 typical cells (CT), one final cell
// (CF). The cell's chain outputs SK/SZ are registered and presented back as the
// next stage's W/L inputs, replacing the combinational CI-CT..CT-CF ripple.
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : synchronous reset, active low (wins over start, aborts a run)
//   bus    : cell_chain_sequencer_if.slave (request, cell slot, results)
// -----------------------------------------------------------------------------
module cell_chain_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cell_chain_sequencer_if.slave  bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FIRST = 3'd1;
  localparam logic [2:0] S_MID   = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IW-1:0] IDX_MID_END = IW'(WIDTH - 2);
  localparam logic [IW-1:0] IDX_LAST    = IW'(WIDTH - 1);

  logic [2:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_k_init;
  logic             r_z_init;
  logic             r_k_q;
  logic             r_z_q;
  logic [WIDTH-1:0] r_res_x;
  logic [WIDTH-1:0] r_res_y;
  logic             r_res_z;
  logic             w_accept;

  // A new request is only taken when no evaluation is in flight.
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Sequencer state, operand latches, chain registers and result collection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_k_init <= 1'b0;
      r_z_init <= 1'b0;
      r_k_q    <= 1'b0;
      r_z_q    <= 1'b0;
      r_res_x  <= '0;
      r_res_y  <= '0;
      r_res_z  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state  <= S_FIRST;
            r_idx    <= '0;
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_k_init <= bus.k_init;
            r_z_init <= bus.z_init;
            r_res_x  <= '0;
            r_res_y  <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FIRST, S_MID: begin
          // Stage idx evaluates this cycle; its chain outputs feed stage idx+1.
          r_k_q          <= bus.cell_sk;
          r_z_q          <= bus.cell_sz;
          r_res_x[r_idx] <= bus.cell_sx;
          r_res_y[r_idx] <= bus.cell_sy;
          if ((r_state == S_MID) && (r_idx == IDX_MID_END)) begin
            r_state <= S_LAST;
            r_idx   <= IDX_LAST;
          end else begin
            r_state <= S_MID;
            r_idx   <= r_idx + IW'(1);
          end
        end
        S_LAST: begin
          // Final cell only contributes SZ; res_x/res_y MSB stays 0.
          r_res_z <= bus.cell_sz;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Moore decode of the cell slot inputs from state and bit index.
  always_comb begin
    bus.cell_sel = 2'd3;
    bus.cell_x   = 1'b0;
    bus.cell_y   = 1'b0;
    bus.cell_k   = 1'b0;
    bus.cell_z   = 1'b0;
    bus.cell_w   = 1'b0;
    bus.cell_l   = 1'b0;
    case (r_state)
      S_FIRST: begin
        bus.cell_sel = 2'd0;
        bus.cell_x   = r_a[0];
        bus.cell_y   = r_b[0];
        bus.cell_k   = r_k_init;
        bus.cell_z   = r_z_init;
      end
      S_MID: begin
        bus.cell_sel = 2'd1;
        bus.cell_x   = r_a[r_idx];
        bus.cell_y   = r_b[r_idx];
        bus.cell_w   = r_k_q;
        bus.cell_l   = r_z_q;
      end
      S_LAST: begin
        bus.cell_sel = 2'd2;
        bus.cell_x   = r_a[WIDTH-1];
        bus.cell_y   = r_b[WIDTH-1];
        bus.cell_w   = r_k_q;
        bus.cell_l   = r_z_q;
      end
      default: begin
        bus.cell_sel = 2'd3;
      end
    endcase
  end

  assign bus.busy  = (r_state == S_FIRST) || (r_state == S_MID) || (r_state == S_LAST);
  assign bus.done  = (r_state == S_DONE);
  assign bus.res_x = r_res_x;
  assign bus.res_y = r_res_y;
  assign bus.res_z = r_res_z;

endmodule

// File: tb/tb_cell_chain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cell_chain_sequencer
// Directed and randomized bench for cell_chain_sequencer. A behavioural cell
// answers the slot combinationally; expected results come from evaluating the
// full ripple chain bit by bit in a plain loop.
// -----------------------------------------------------------------------------
module tb_cell_chain_sequencer;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_chain_sequencer_if #(.WIDTH(W)) u_if ();

  cell_chain_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int checks = 0;
  int errors = 0;

  logic         force_en = 1'b0;
  logic         force_sk = 1'b0;
  logic [W-2:0] cur_pat  = '0;
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  logic         cur_k;
  logic         cur_z;

  logic [W-1:0] m_rx;
  logic [W-1:0] m_ry;
  logic         m_rz;
  logic         m_w [W];
  logic         m_l [W];

  // Behavioural cell: {sx, sy, sk, sz}; final cell uses a different SZ rule.
  function automatic logic [3:0] cell_eval(input logic [1:0] sel, input logic x, input logic y,
                                           input logic kin, input logic zin);
    logic sx, sy, sk, sz;
    sx = x ^ y ^ kin;
    sy = (x & y) | zin;
    sk = (x & y) | (x & kin) | (y & kin);
    sz = (sel == 2'd2) ? (zin ^ x ^ y) : (zin ^ (x | y));
    return {sx, sy, sk, sz};
  endfunction

  logic [3:0] cell_r;
  // Cell slot model; final-cell SX/SY/SK are driven as junk to prove they are ignored.
  always_comb begin
    cell_r = cell_eval(u_if.cell_sel, u_if.cell_x, u_if.cell_y,
                       (u_if.cell_sel == 2'd0) ? u_if.cell_k : u_if.cell_w,
                       (u_if.cell_sel == 2'd0) ? u_if.cell_z : u_if.cell_l);
    u_if.cell_sx = cell_r[3];
    u_if.cell_sy = cell_r[2];
    u_if.cell_sk = force_en ? force_sk : cell_r[1];
    u_if.cell_sz = cell_r[0];
    if (u_if.cell_sel == 2'd2) begin
      u_if.cell_sx = 1'b1;
      u_if.cell_sy = 1'b1;
      u_if.cell_sk = 1'b1;
    end
  end

  // Reference: the whole combinational chain evaluated as a ripple loop.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic k,
                       input logic z, input logic fe, input logic [W-2:0] pat);
    logic kk, zz;
    logic [3:0] r;
    kk = k;
    zz = z;
    m_rx = '0;
    m_ry = '0;
    m_w[0] = 1'b0;
    m_l[0] = 1'b0;
    for (int i = 0; i < W - 1; i++) begin
      r = cell_eval((i == 0) ? 2'd0 : 2'd1, a[i], b[i], kk, zz);
      m_rx[i] = r[3];
      m_ry[i] = r[2];
      kk = fe ? pat[i] : r[1];
      zz = r[0];
      m_w[i+1] = kk;
      m_l[i+1] = zz;
    end
    r = cell_eval(2'd2, a[W-1], b[W-1], kk, zz);
    m_rz = r[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic k,
                          input logic z, input logic fe, input logic [W-2:0] pat);
    cur_a = a; cur_b = b; cur_k = k; cur_z = z; cur_pat = pat;
    u_if.a = a; u_if.b = b; u_if.k_init = k; u_if.z_init = z;
    u_if.start = 1'b1;
    force_en = fe;
    model(a, b, k, z, fe, pat);
  endtask

  // Called with start asserted before the sampling edge; returns in the DONE cycle.
  task automatic run_body(input logic [31:0] pulse_mask);
    tick();
    u_if.start = 1'b0;
    chk("res_x_cleared", u_if.res_x, 32'd0);
    chk("res_y_cleared", u_if.res_y, 32'd0);
    for (int c = 1; c <= W; c++) begin
      u_if.a = W'($urandom);
      u_if.b = W'($urandom);
      u_if.k_init = 1'($urandom);
      u_if.z_init = 1'($urandom);
      u_if.start = pulse_mask[c];
      if (c <= W - 1) force_sk = cur_pat[c-1];
      chk("cell_sel", u_if.cell_sel, (c == 1) ? 32'd0 : ((c == W) ? 32'd2 : 32'd1));
      chk("cell_x", u_if.cell_x, cur_a[c-1]);
      chk("cell_y", u_if.cell_y, cur_b[c-1]);
      chk("busy_run", u_if.busy, 32'd1);
      chk("done_run", u_if.done, 32'd0);
      if (c == 1) begin
        chk("cell_k", u_if.cell_k, cur_k);
        chk("cell_z", u_if.cell_z, cur_z);
        chk("cell_w_first", u_if.cell_w, 32'd0);
      end else begin
        chk("cell_w", u_if.cell_w, m_w[c-1]);
        chk("cell_l", u_if.cell_l, m_l[c-1]);
        chk("cell_k_zero", u_if.cell_k, 32'd0);
      end
      tick();
    end
    u_if.start = 1'b0;
    chk("done_pulse", u_if.done, 32'd1);
    chk("busy_done", u_if.busy, 32'd0);
    chk("sel_done", u_if.cell_sel, 32'd3);
    chk("res_x", u_if.res_x, m_rx);
    chk("res_y", u_if.res_y, m_ry);
    chk("res_z", u_if.res_z, m_rz);
  endtask

  task automatic after_done();
    u_if.start = 1'b0;
    tick();
    chk("done_one_cycle", u_if.done, 32'd0);
    chk("busy_idle", u_if.busy, 32'd0);
    chk("sel_idle", u_if.cell_sel, 32'd3);
    chk("res_x_hold", u_if.res_x, m_rx);
    chk("res_z_hold", u_if.res_z, m_rz);
  endtask

  initial begin
    u_if.start = 1'b0;
    u_if.a = '0; u_if.b = '0; u_if.k_init = 1'b0; u_if.z_init = 1'b0;

    // Reset held with start high: nothing may start.
    rst_n = 1'b0;
    u_if.start = 1'b1;
    u_if.a = 8'hFF; u_if.b = 8'hFF; u_if.k_init = 1'b1; u_if.z_init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", u_if.busy, 32'd0);
      chk("rst_done", u_if.done, 32'd0);
      chk("rst_sel", u_if.cell_sel, 32'd3);
      chk("rst_res_x", u_if.res_x, 32'd0);
      chk("rst_res_y", u_if.res_y, 32'd0);
      chk("rst_res_z", u_if.res_z, 32'd0);
      chk("rst_cell_x", u_if.cell_x, 32'd0);
      chk("rst_cell_w", u_if.cell_w, 32'd0);
    end
    u_if.start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_sel", u_if.cell_sel, 32'd3);

    // Directed operand pair.
    start_op(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 7'd0);
    run_body(32'd0);
    after_done();

    // Forced SK pattern 1,0,1,1,0,0,1 must reappear on cell_w in cycles 2..8.
    start_op(W'($urandom), W'($urandom), 1'b0, 1'b1, 1'b1, 7'b1001101);
    run_body(32'd0);
    force_en = 1'b0;
    after_done();

    // Start pulses during the run are ignored.
    start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, 7'd0);
    run_body((32'd1 << 3) | (32'd1 << 6));
    after_done();

    // Back-to-back: start high in DONE begins the next op immediately.
    start_op(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 7'd0);
    run_body(32'd0);
    start_op(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 7'd0);
    run_body(32'hFFFF_FFFF);
    after_done();

    // Reset in cycle 4 aborts the run.
    start_op(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 7'd0);
    tick();
    u_if.start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_sel", u_if.cell_sel, 32'd3);
    chk("abort_busy", u_if.busy, 32'd0);
    chk("abort_done", u_if.done, 32'd0);
    chk("abort_res_x", u_if.res_x, 32'd0);
    chk("abort_res_y", u_if.res_y, 32'd0);
    chk("abort_res_z", u_if.res_z, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort_no_done", u_if.done, 32'd0);
    end
    start_op(8'h96, 8'h69, 1'b0, 1'b1, 1'b0, 7'd0);
    run_body(32'd0);
    after_done();

    // Randomized operations against the ripple-chain reference.
    for (int n = 0; n < 24; n++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, 7'd0);
      run_body(32'd0);
      if (n % 3 == 0) after_done();
    end
    after_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
